// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the step sequencer
package seq_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam int DEF_NUM_STEPS = 8;
    localparam int DEF_NOTE_W    = 4;
    localparam int BEAT_CYCLES   = 5000000;

    // One pattern slot at the default note width: play/rest flag plus note code
    typedef struct packed {
        logic                  valid;
        logic [DEF_NOTE_W-1:0] note;
    } step_t;

endpackage

// File: rtl/seq_gate_timer.sv
// rtl/seq_gate_timer.sv - per-step gate down-counter, reloaded at each step start
module seq_gate_timer #(
    parameter int GATE_CYCLES = 2500000
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_load,
    input  logic i_valid,
    input  logic i_stop,
    output logic o_gate
);
    localparam int CNT_W = $clog2(GATE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GATE_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_gate;

    // Count holds the cycles left including the current one; gate drops once it reaches 1
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_gate <= 1'b0;
        end else if (i_stop) begin
            r_cnt  <= '0;
            r_gate <= 1'b0;
        end else if (i_load) begin
            r_cnt  <= LOAD_VAL;
            r_gate <= i_valid;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            r_gate <= r_gate && (r_cnt > CNT_W'(1));
        end
    end

    assign o_gate = r_gate;

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - beat-driven step pattern engine with record and gate output
module step_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_STEPS   = DEF_NUM_STEPS,
    parameter int NOTE_W      = DEF_NOTE_W,
    parameter int GATE_CYCLES = BEAT_CYCLES / 2
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         sequencer_on,
    input  logic                         beat_pulse,
    input  logic                         rec_en,
    input  logic                         key_valid,
    input  logic [NOTE_W-1:0]            key_note,
    input  logic                         key_rest,
    input  logic                         clear_all,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic [NUM_STEPS-1:0]         step_onehot,
    output logic                         step_start,
    output logic [NOTE_W-1:0]            note_out,
    output logic                         gate
);
    localparam int IDX_W = $clog2(NUM_STEPS);

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [IDX_W-1:0]     r_step_idx;
    logic [IDX_W-1:0]     w_next_idx;
    logic [NUM_STEPS-1:0] r_onehot;
    logic [NUM_STEPS-1:0] w_next_onehot;
    logic                 r_step_start;
    logic                 w_start;
    logic [NOTE_W-1:0]    r_note;
    logic [NOTE_W-1:0]    w_next_note;
    logic                 w_next_valid;
    logic                 w_gate;
    logic [NUM_STEPS-1:0] r_valid;
    logic [NOTE_W-1:0]    r_notes [NUM_STEPS];

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: the run enable alone decides between IDLE and RUN
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (sequencer_on)  w_state_next = RUN;
            RUN:     if (!sequencer_on) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next output values: a step starts on entering RUN (at step 0) or on a beat while running
    always_comb begin
        w_start    = 1'b0;
        w_next_idx = r_step_idx;
        case (r_state)
            IDLE: begin
                if (sequencer_on) begin
                    w_start    = 1'b1;
                    w_next_idx = '0;
                end
            end
            RUN: begin
                if (!sequencer_on) begin
                    w_next_idx = '0;
                end else if (beat_pulse) begin
                    w_start    = 1'b1;
                    w_next_idx = r_step_idx + 1'b1;
                end
            end
            default: w_next_idx = '0;
        endcase
        w_next_onehot = '0;
        if (w_state_next == RUN) begin
            w_next_onehot[w_next_idx] = 1'b1;
        end
        w_next_note  = w_start ? r_notes[w_next_idx] : r_note;
        w_next_valid = r_valid[w_next_idx];
    end

    // Output registers; note_out holds its last value while idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_step_idx   <= '0;
            r_onehot     <= '0;
            r_step_start <= 1'b0;
            r_note       <= '0;
        end else begin
            r_step_idx   <= w_next_idx;
            r_onehot     <= w_next_onehot;
            r_step_start <= w_start;
            r_note       <= w_next_note;
        end
    end

    // Pattern memory: clear_all beats rest, rest beats a key write; writes hit the pre-advance step
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                r_notes[i] <= '0;
            end
        end else if (clear_all) begin
            r_valid <= '0;
        end else if (rec_en && key_rest) begin
            r_valid[r_step_idx] <= 1'b0;
        end else if (rec_en && key_valid) begin
            r_valid[r_step_idx] <= 1'b1;
            r_notes[r_step_idx] <= key_note;
        end
    end

    seq_gate_timer #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_gate_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .i_load (w_start),
        .i_valid(w_next_valid),
        .i_stop (!sequencer_on),
        .o_gate (w_gate)
    );

    assign step_idx    = r_step_idx;
    assign step_onehot = r_onehot;
    assign step_start  = r_step_start;
    assign note_out    = r_note;
    assign gate        = w_gate;

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - self-checking bench for step_sequencer
module tb_step_sequencer;
    localparam int N   = 8;
    localparam int G_A = 4;
    localparam int G_B = 20;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sequencer_on = 1'b0;
    logic       beat_pulse = 1'b0;
    logic       rec_en = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_note = 4'h0;
    logic       key_rest = 1'b0;
    logic       clear_all = 1'b0;

    logic [2:0] idx_a, idx_b;
    logic [7:0] oh_a, oh_b;
    logic       ss_a, ss_b, gate_a, gate_b;
    logic [3:0] note_a, note_b;

    always #5 clk = ~clk;

    step_sequencer #(.NUM_STEPS(N), .NOTE_W(4), .GATE_CYCLES(G_A)) dut_a (
        .clk(clk), .n_rst(n_rst), .sequencer_on(sequencer_on), .beat_pulse(beat_pulse),
        .rec_en(rec_en), .key_valid(key_valid), .key_note(key_note), .key_rest(key_rest),
        .clear_all(clear_all), .step_idx(idx_a), .step_onehot(oh_a), .step_start(ss_a),
        .note_out(note_a), .gate(gate_a)
    );

    step_sequencer #(.NUM_STEPS(N), .NOTE_W(4), .GATE_CYCLES(G_B)) dut_b (
        .clk(clk), .n_rst(n_rst), .sequencer_on(sequencer_on), .beat_pulse(beat_pulse),
        .rec_en(rec_en), .key_valid(key_valid), .key_note(key_note), .key_rest(key_rest),
        .clear_all(clear_all), .step_idx(idx_b), .step_onehot(oh_b), .step_start(ss_b),
        .note_out(note_b), .gate(gate_b)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: running flag, step index, cycles since the step began, pattern arrays
    bit m_run;
    int m_idx;
    int m_age;
    bit m_sound;
    int m_note;
    int m_pnote [N];
    bit m_pvalid [N];

    typedef struct {
        bit on, beat, rec, kv, kr, clr;
        int note;
        int e_idx;
        bit e_ss, e_gate;
        int e_note;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(bit on, bit beat, bit rec, bit kv, bit kr, bit clr, int note,
                                int e_idx, bit e_ss, bit e_gate, int e_note);
        vec_t v;
        v.on = on; v.beat = beat; v.rec = rec; v.kv = kv; v.kr = kr; v.clr = clr;
        v.note = note; v.e_idx = e_idx; v.e_ss = e_ss; v.e_gate = e_gate; v.e_note = e_note;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  old_idx;
        bit  started;
        old_idx = m_idx;
        started = 1'b0;
        if (!n_rst) begin
            m_run = 0; m_idx = 0; m_age = 1000; m_sound = 0; m_note = 0;
            for (int i = 0; i < N; i++) begin
                m_pnote[i] = 0;
                m_pvalid[i] = 0;
            end
        end else begin
            if (!sequencer_on) begin
                m_run = 0;
                m_idx = 0;
            end else if (!m_run) begin
                m_run = 1;
                m_idx = 0;
                started = 1;
            end else if (beat_pulse) begin
                m_idx = (m_idx + 1) % N;
                started = 1;
            end
            if (started) begin
                m_age = 0;
                m_note = m_pnote[m_idx];
                m_sound = m_pvalid[m_idx];
            end else if (m_age < 1000) begin
                m_age++;
            end
            if (clear_all) begin
                for (int i = 0; i < N; i++) m_pvalid[i] = 0;
            end else if (rec_en && key_rest) begin
                m_pvalid[old_idx] = 0;
            end else if (rec_en && key_valid) begin
                m_pvalid[old_idx] = 1;
                m_pnote[old_idx] = int'(key_note);
            end
        end
    endtask

    task automatic check_all();
        int e_oh;
        bit e_ss, e_ga, e_gb;
        e_oh = m_run ? (1 << m_idx) : 0;
        e_ss = m_run && (m_age == 0);
        e_ga = m_run && m_sound && (m_age < G_A);
        e_gb = m_run && m_sound && (m_age < G_B);
        chk("a_idx", 32'(idx_a), 32'(m_idx));
        chk("a_onehot", 32'(oh_a), 32'(e_oh));
        chk("a_start", 32'(ss_a), 32'(e_ss));
        chk("a_note", 32'(note_a), 32'(m_note));
        chk("a_gate", 32'(gate_a), 32'(e_ga));
        chk("b_idx", 32'(idx_b), 32'(m_idx));
        chk("b_onehot", 32'(oh_b), 32'(e_oh));
        chk("b_start", 32'(ss_b), 32'(e_ss));
        chk("b_note", 32'(note_b), 32'(m_note));
        chk("b_gate", 32'(gate_b), 32'(e_gb));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        beat_pulse = 0; rec_en = 0; key_valid = 0; key_rest = 0; clear_all = 0; key_note = 4'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        sequencer_on = 0;
        n_rst = 0;
        tick();
        tick();
        n_rst = 1;
        tick();
    endtask

    task automatic beat_after(input int n);
        repeat (n) tick();
        beat_pulse = 1;
        tick();
        beat_pulse = 0;
    endtask

    task automatic record(input int note);
        rec_en = 1; key_valid = 1; key_note = 4'(note);
        tick();
        rec_en = 0; key_valid = 0;
    endtask

    initial begin
        int w;

        // Table-driven opening sequence, expectations for GATE_CYCLES=4
        tbl[0]  = mk(0,0,0,0,0,0,0,  0,0,0,0);
        tbl[1]  = mk(1,0,0,0,0,0,0,  0,1,0,0);
        tbl[2]  = mk(1,0,1,1,0,0,5,  0,0,0,0);
        tbl[3]  = mk(1,1,0,0,0,0,0,  1,1,0,0);
        tbl[4]  = mk(1,0,1,1,1,0,9,  1,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,  0,0,0,0);
        tbl[6]  = mk(0,1,0,0,0,0,0,  0,0,0,0);
        tbl[7]  = mk(1,0,0,0,0,0,0,  0,1,1,5);
        tbl[8]  = mk(1,0,0,0,0,0,0,  0,0,1,5);
        tbl[9]  = mk(1,1,0,0,0,0,0,  1,1,0,0);
        tbl[10] = mk(1,0,1,1,0,1,3,  1,0,0,0);
        tbl[11] = mk(1,1,0,0,0,0,0,  2,1,0,0);
        tbl[12] = mk(1,1,0,0,0,0,0,  3,1,0,0);
        tbl[13] = mk(1,1,0,0,0,0,0,  4,1,0,0);
        tbl[14] = mk(1,1,0,0,0,0,0,  5,1,0,0);
        tbl[15] = mk(1,1,0,0,0,0,0,  6,1,0,0);
        tbl[16] = mk(1,1,0,0,0,0,0,  7,1,0,0);
        tbl[17] = mk(1,1,0,0,0,0,0,  0,1,0,5);

        do_reset();
        for (int i = 0; i < 18; i++) begin
            sequencer_on = tbl[i].on; beat_pulse = tbl[i].beat; rec_en = tbl[i].rec;
            key_valid = tbl[i].kv; key_rest = tbl[i].kr; clear_all = tbl[i].clr;
            key_note = 4'(tbl[i].note);
            tick();
            chk("tbl_idx", 32'(idx_a), 32'(tbl[i].e_idx));
            chk("tbl_start", 32'(ss_a), 32'(tbl[i].e_ss));
            chk("tbl_gate", 32'(gate_a), 32'(tbl[i].e_gate));
            chk("tbl_note", 32'(note_a), 32'(tbl[i].e_note));
        end
        idle_inputs();

        // Start from reset with an empty pattern
        do_reset();
        sequencer_on = 1;
        tick();
        chk("start_ss", 32'(ss_a), 32'd1);
        chk("start_idx", 32'(idx_a), 32'd0);
        chk("start_oh", 32'(oh_a), 32'h01);
        chk("start_gate", 32'(gate_a), 32'd0);

        // Record 4'hA at step 3 and hear it on the next visit
        repeat (3) beat_after(9);
        record(10);
        beat_after(8);
        repeat (7) beat_after(9);
        chk("rec3_note", 32'(note_a), 32'hA);
        chk("rec3_ss", 32'(ss_a), 32'd1);
        w = int'(gate_a);
        repeat (9) begin tick(); w += int'(gate_a); end
        chk("rec3_gate_width", 32'(w), 32'd4);

        // All eight steps valid, then nine beats through the wrap
        do_reset();
        sequencer_on = 1;
        tick();
        for (int s = 0; s < N; s++) begin
            record(s + 1);
            beat_after(8);
        end
        repeat (9) tick();
        for (int b = 0; b < 9; b++) begin
            beat_pulse = 1;
            tick();
            beat_pulse = 0;
            chk("seq_idx", 32'(idx_a), 32'((b + 1) % N));
            if (b == 6) chk("wrap_oh7", 32'(oh_a), 32'h80);
            if (b == 7) chk("wrap_oh0", 32'(oh_a), 32'h01);
            w = int'(gate_a);
            repeat (9) begin tick(); w += int'(gate_a); end
            chk("seq_gate_width", 32'(w), 32'd4);
        end

        // Beat plus key_valid and key_rest together at step 5
        beat_pulse = 1; tick(); beat_pulse = 0;
        repeat (3) beat_after(9);
        repeat (9) tick();
        beat_pulse = 1; rec_en = 1; key_valid = 1; key_rest = 1; key_note = 4'hF;
        tick();
        idle_inputs();
        chk("s6_idx", 32'(idx_a), 32'd6);
        chk("s6_gate", 32'(gate_a), 32'd1);
        chk("s6_note", 32'(note_a), 32'd7);
        repeat (7) beat_after(9);
        chk("s5_idx", 32'(idx_a), 32'd5);
        chk("s5_rest_gate", 32'(gate_a), 32'd0);
        beat_after(9);
        rec_en = 1; key_valid = 1; clear_all = 1; key_note = 4'h3;
        tick();
        idle_inputs();
        chk("clr_keeps_gate", 32'(gate_a), 32'd1);
        beat_after(8);
        chk("clr_s7_gate", 32'(gate_a), 32'd0);
        chk("clr_s7_note", 32'(note_a), 32'd8);

        // Long gate: steps 2 and 3 valid, step 3 stretched to see the reload
        do_reset();
        sequencer_on = 1;
        tick();
        beat_after(9);
        beat_after(9);
        record(1);
        beat_after(8);
        record(2);
        beat_after(8);
        repeat (6) beat_after(9);
        chk("long_s2_idx", 32'(idx_b), 32'd2);
        w = int'(gate_b);
        repeat (9) begin tick(); w += int'(gate_b); end
        beat_pulse = 1; tick(); beat_pulse = 0;
        chk("long_s3_ss", 32'(ss_b), 32'd1);
        chk("long_s3_gate", 32'(gate_b), 32'd1);
        w += int'(gate_b);
        repeat (24) begin tick(); w += int'(gate_b); end
        chk("long_gate_total", 32'(w), 32'd30);

        // Stop mid-gate at step 4, restart, then asynchronous reset
        do_reset();
        sequencer_on = 1;
        tick();
        record(2);
        beat_after(8);
        repeat (3) beat_after(9);
        record(6);
        beat_after(8);
        repeat (7) beat_after(9);
        tick();
        chk("stop_pre_gate", 32'(gate_a), 32'd1);
        sequencer_on = 0;
        tick();
        chk("stop_gate", 32'(gate_a), 32'd0);
        chk("stop_idx", 32'(idx_a), 32'd0);
        chk("stop_oh", 32'(oh_a), 32'd0);
        chk("stop_note_hold", 32'(note_a), 32'd6);
        beat_pulse = 1; tick(); beat_pulse = 0;
        chk("idle_beat_idx", 32'(idx_a), 32'd0);
        chk("idle_beat_ss", 32'(ss_a), 32'd0);
        sequencer_on = 1;
        tick();
        chk("restart_ss", 32'(ss_a), 32'd1);
        chk("restart_note", 32'(note_a), 32'd2);
        chk("restart_gate", 32'(gate_a), 32'd1);
        repeat (3) tick();
        #2 n_rst = 0;
        #1;
        chk("arst_idx", 32'(idx_a), 32'd0);
        chk("arst_oh", 32'(oh_a), 32'd0);
        chk("arst_ss", 32'(ss_a), 32'd0);
        chk("arst_note", 32'(note_a), 32'd0);
        chk("arst_gate", 32'(gate_a), 32'd0);
        chk("arst_gate_b", 32'(gate_b), 32'd0);
        tick();
        n_rst = 1;
        tick();
        chk("post_rst_ss", 32'(ss_a), 32'd1);
        chk("post_rst_note", 32'(note_a), 32'd0);
        chk("post_rst_gate", 32'(gate_a), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            sequencer_on = ($urandom_range(0, 49) != 0);
            beat_pulse   = ($urandom_range(0, 5) == 0);
            rec_en       = ($urandom_range(0, 1) == 1);
            key_valid    = ($urandom_range(0, 4) == 0);
            key_rest     = ($urandom_range(0, 7) == 0);
            clear_all    = ($urandom_range(0, 39) == 0);
            key_note     = 4'($urandom_range(0, 15));
            tick();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
